// File: rtl/tiny32_intc.sv
// Nesting vectored interrupt controller for tiny32: N channels with edge/level mode,
// fixed priority (highest index wins) and a bounded stack of active handler numbers.
module tiny32_intc #(
  parameter int unsigned NUM_IRQ     = 8,
  parameter int unsigned NEST_DEPTH  = 2,
  parameter logic [23:0] ISR_ADDRESS = 24'h0
) (
  input  logic               clk,
  input  logic               nreset,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic               irq_req,
  output logic [31:0]        irq_vector,
  input  logic               irq_take,
  input  logic               irq_ret,
  output logic [NUM_IRQ-1:0] irq_ack,
  input  logic               reg_sel,
  input  logic               reg_wr,
  input  logic [1:0]         reg_addr,
  input  logic [31:0]        reg_wdata,
  output logic [31:0]        reg_rdata
);

  localparam logic [3:0] MaxDepth = 4'(NEST_DEPTH);

  logic [NUM_IRQ-1:0] sync_q, sync_prev_q;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] enable_q, enable_d;
  logic [NUM_IRQ-1:0] mode_q, mode_d;
  logic [3:0]         stack_q [NEST_DEPTH];
  logic [3:0]         stack_d [NEST_DEPTH];
  logic [3:0]         depth_q, depth_d, pop_depth;
  logic               uflow_q, uflow_d;
  logic               req_q, req_d;
  logic [3:0]         req_num_q;
  logic [31:0]        vector_q, vector_d;
  logic [31:0]        rdata_q, rdata_d;

  logic               wr_en, rd_en, take_ok;
  logic [NUM_IRQ-1:0] eligible, rise, take_clr, w1c;
  logic [3:0]         win_num, top_now, top_next;
  logic               unused_wdata;

  assign wr_en        = reg_sel & reg_wr;
  assign rd_en        = reg_sel & ~reg_wr;
  assign take_ok      = irq_take & req_q;
  assign unused_wdata = ^reg_wdata;

  // Entry i holds the handler number at stack position i; depth counts valid entries.
  function automatic logic [3:0] top_of(input logic [3:0] stk [NEST_DEPTH],
                                        input logic [3:0] dep);
    logic [3:0] t;
    t = '0;
    for (int unsigned i = 0; i < NEST_DEPTH; i++) begin
      if (4'(i + 1) == dep) t = stk[i];
    end
    return t;
  endfunction

  always_comb begin
    eligible = pending_q & enable_q;
    win_num  = '0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (eligible[i]) win_num = 4'(i + 1);
    end
  end

  // Pop is applied before push when ret and take coincide.
  always_comb begin
    stack_d   = stack_q;
    uflow_d   = uflow_q;
    pop_depth = depth_q;
    if (wr_en && reg_addr == 2'd3 && reg_wdata[8]) uflow_d = 1'b0;
    if (irq_ret) begin
      if (depth_q == '0) uflow_d = 1'b1;
      else               pop_depth = depth_q - 4'd1;
    end
    depth_d = pop_depth;
    if (take_ok) begin
      for (int unsigned i = 0; i < NEST_DEPTH; i++) begin
        if (4'(i) == pop_depth) stack_d[i] = req_num_q;
      end
      depth_d = pop_depth + 4'd1;
    end
  end

  // Edge latches: a fresh rising edge wins over take-clear and W1C in the same cycle.
  always_comb begin
    take_clr = '0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (take_ok && req_num_q == 4'(i + 1)) take_clr[i] = 1'b1;
    end
    w1c       = (wr_en && reg_addr == 2'd2) ? reg_wdata[NUM_IRQ-1:0] : '0;
    rise      = sync_q & ~sync_prev_q;
    pending_d = (mode_q & (rise | (pending_q & ~(take_clr | w1c)))) | (~mode_q & sync_q);
  end

  always_comb begin
    enable_d = (wr_en && reg_addr == 2'd0) ? reg_wdata[NUM_IRQ-1:0] : enable_q;
    mode_d   = (wr_en && reg_addr == 2'd1) ? reg_wdata[NUM_IRQ-1:0] : mode_q;
  end

  always_comb begin
    top_now  = top_of(stack_q, depth_q);
    top_next = top_of(stack_d, depth_d);
    req_d    = (win_num > top_next) && (depth_d < MaxDepth);
    vector_d = {ISR_ADDRESS, 2'b00, win_num, 2'b00};
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      unique case (reg_addr)
        2'd0:    rdata_d = 32'(enable_q);
        2'd1:    rdata_d = 32'(mode_q);
        2'd2:    rdata_d = 32'(pending_q);
        default: rdata_d = {23'b0, uflow_q, depth_q, top_now};
      endcase
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      irq_ack[i] = (top_now == 4'(i + 1));
    end
  end

  assign irq_req    = req_q;
  assign irq_vector = vector_q;
  assign reg_rdata  = rdata_q;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      sync_q      <= '0;
      sync_prev_q <= '0;
      pending_q   <= '0;
      enable_q    <= '1;
      mode_q      <= '0;
      for (int unsigned i = 0; i < NEST_DEPTH; i++) stack_q[i] <= '0;
      depth_q     <= '0;
      uflow_q     <= 1'b0;
      req_q       <= 1'b0;
      req_num_q   <= '0;
      vector_q    <= {ISR_ADDRESS, 8'h00};
      rdata_q     <= '0;
    end else begin
      sync_q      <= irq_in;
      sync_prev_q <= sync_q;
      pending_q   <= pending_d;
      enable_q    <= enable_d;
      mode_q      <= mode_d;
      stack_q     <= stack_d;
      depth_q     <= depth_d;
      uflow_q     <= uflow_d;
      req_q       <= req_d;
      req_num_q   <= win_num;
      vector_q    <= vector_d;
      rdata_q     <= rdata_d;
    end
  end

endmodule

// File: tb/tb_tiny32_intc.sv
// Directed bench for tiny32_intc: a queue-based reference model checked every cycle,
// plus literal expectations for the key scenarios.
module tb_tiny32_intc;

  localparam int          NIrq  = 8;
  localparam int          Depth = 2;
  localparam logic [31:0] Base  = 32'h0001_0000;

  logic            clk = 1'b0;
  logic            nreset = 1'b0;
  logic [NIrq-1:0] irq_in = '0;
  logic            irq_req;
  logic [31:0]     irq_vector;
  logic            irq_take = 1'b0;
  logic            irq_ret = 1'b0;
  logic [NIrq-1:0] irq_ack;
  logic            reg_sel = 1'b0;
  logic            reg_wr = 1'b0;
  logic [1:0]      reg_addr = '0;
  logic [31:0]     reg_wdata = '0;
  logic [31:0]     reg_rdata;

  tiny32_intc #(
    .NUM_IRQ    (NIrq),
    .NEST_DEPTH (Depth),
    .ISR_ADDRESS(24'h000100)
  ) dut (
    .clk       (clk),
    .nreset    (nreset),
    .irq_in    (irq_in),
    .irq_req   (irq_req),
    .irq_vector(irq_vector),
    .irq_take  (irq_take),
    .irq_ret   (irq_ret),
    .irq_ack   (irq_ack),
    .reg_sel   (reg_sel),
    .reg_wr    (reg_wr),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata)
  );

  initial forever #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit armed = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [NIrq-1:0] m_sync, m_prev, m_pend, m_en, m_mode, m_newp;
  int              m_stack[$];
  bit              m_uflow, m_req, m_take_ok, m_clr;
  int              m_num, m_win, m_taken, m_top;
  logic [31:0]     m_rdata;

  function automatic int stack_top();
    return (m_stack.size() == 0) ? 0 : m_stack[$];
  endfunction

  task automatic model_step();
    if (!nreset) begin
      m_sync = '0; m_prev = '0; m_pend = '0; m_en = '1; m_mode = '0;
      m_stack.delete();
      m_uflow = 0; m_req = 0; m_num = 0; m_rdata = '0;
    end else begin
      m_win = 0;
      for (int i = 0; i < NIrq; i++) if (m_pend[i] && m_en[i]) m_win = i + 1;
      m_take_ok = irq_take && m_req;
      m_taken   = m_num;
      if (reg_sel && !reg_wr) begin
        case (reg_addr)
          2'd0: m_rdata = 32'(m_en);
          2'd1: m_rdata = 32'(m_mode);
          2'd2: m_rdata = 32'(m_pend);
          default: m_rdata = (m_uflow ? 32'h100 : 32'h0) + (m_stack.size() << 4) + stack_top();
        endcase
      end
      if (reg_sel && reg_wr && reg_addr == 2'd3 && reg_wdata[8]) m_uflow = 0;
      if (irq_ret) begin
        if (m_stack.size() == 0) m_uflow = 1;
        else void'(m_stack.pop_back());
      end
      if (m_take_ok) m_stack.push_back(m_taken);
      for (int i = 0; i < NIrq; i++) begin
        m_clr = (m_take_ok && m_taken == i + 1) ||
                (reg_sel && reg_wr && reg_addr == 2'd2 && reg_wdata[i]);
        if (m_mode[i]) m_newp[i] = (m_sync[i] && !m_prev[i]) || (m_pend[i] && !m_clr);
        else           m_newp[i] = m_sync[i];
      end
      if (reg_sel && reg_wr && reg_addr == 2'd0) m_en   = reg_wdata[NIrq-1:0];
      if (reg_sel && reg_wr && reg_addr == 2'd1) m_mode = reg_wdata[NIrq-1:0];
      m_top  = stack_top();
      m_req  = (m_win > m_top) && (m_stack.size() < Depth);
      m_num  = m_win;
      m_pend = m_newp;
      m_prev = m_sync;
      m_sync = irq_in;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("req", 32'(irq_req), 32'(m_req));
      if (m_req) chk("vector", irq_vector, Base | 32'(m_num << 2));
      chk("ack", 32'(irq_ack),
          (m_stack.size() == 0) ? 32'h0 : (32'h1 << (m_stack[$] - 1)));
      chk("rdata", reg_rdata, m_rdata);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
    reg_sel = 1'b1; reg_wr = 1'b1; reg_addr = a; reg_wdata = d;
    tick();
    reg_sel = 1'b0; reg_wr = 1'b0; reg_wdata = '0;
  endtask

  task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
    reg_sel = 1'b1; reg_wr = 1'b0; reg_addr = a;
    tick();
    reg_sel = 1'b0;
    d = reg_rdata;
  endtask

  task automatic pulse_take();
    irq_take = 1'b1; tick(); irq_take = 1'b0;
  endtask

  task automatic pulse_ret();
    irq_ret = 1'b1; tick(); irq_ret = 1'b0;
  endtask

  logic [31:0] d;
  int          lat;

  initial begin
    tick(2);
    armed = 1'b1;
    chk("rst_req", 32'(irq_req), 32'h0);
    chk("rst_vector", irq_vector, 32'h0001_0000);
    chk("rst_ack", 32'(irq_ack), 32'h0);
    chk("rst_rdata", reg_rdata, 32'h0);
    nreset = 1'b1;
    tick();

    // 1: level request on ch2, latency and vector
    irq_in[2] = 1'b1;
    lat = 0;
    while (!irq_req && lat < 10) begin tick(); lat++; end
    chk("t1_latency", 32'(lat), 32'd3);
    chk("t1_vector", irq_vector, 32'h0001_000C);
    pulse_take();
    chk("t1_ack", 32'(irq_ack), 32'h04);
    reg_read(2'd3, d);
    chk("t1_status", d, 32'h13);
    irq_in[2] = 1'b0;
    tick(3);
    pulse_ret();
    tick(2);

    // 2: priority between ch1 and ch6
    irq_in[1] = 1'b1; irq_in[6] = 1'b1;
    tick(3);
    chk("t2_req", 32'(irq_req), 32'h1);
    chk("t2_vec7", irq_vector, 32'h0001_001C);
    pulse_take();
    irq_in[6] = 1'b0;
    tick(3);
    chk("t2_hold", 32'(irq_req), 32'h0);
    pulse_ret();
    chk("t2_vec2", irq_vector, 32'h0001_0008);
    pulse_take();
    irq_in[1] = 1'b0;
    tick(3);
    pulse_ret();
    tick(2);

    // 3: nesting to full depth
    irq_in[1] = 1'b1;
    tick(3);
    pulse_take();
    irq_in[1] = 1'b0;
    irq_in[5] = 1'b1;
    tick(3);
    chk("t3_vec6", irq_vector, 32'h0001_0018);
    pulse_take();
    irq_in[5] = 1'b0;
    reg_read(2'd3, d);
    chk("t3_status", d, 32'h26);
    irq_in[7] = 1'b1;
    tick(4);
    chk("t3_full", 32'(irq_req), 32'h0);
    pulse_ret();
    chk("t3_req8", 32'(irq_req), 32'h1);
    chk("t3_vec8", irq_vector, 32'h0001_0020);
    pulse_take();
    irq_in[7] = 1'b0;
    tick(3);
    pulse_ret();
    pulse_ret();
    reg_read(2'd3, d);
    chk("t3_empty", d, 32'h0);

    // 4: edge mode on ch0, masking, W1C vs rising edge
    reg_write(2'd1, 32'h01);
    reg_write(2'd0, 32'hFE);
    irq_in[0] = 1'b1; tick(); irq_in[0] = 1'b0;
    tick(3);
    reg_read(2'd2, d);
    chk("t4_latch", d, 32'h01);
    chk("t4_masked", 32'(irq_req), 32'h0);
    reg_write(2'd2, 32'h01);
    reg_read(2'd2, d);
    chk("t4_w1c", d, 32'h00);
    irq_in[0] = 1'b1; tick();
    irq_in[0] = 1'b0;
    reg_write(2'd2, 32'h01);
    reg_read(2'd2, d);
    chk("t4_setwins", d, 32'h01);
    reg_write(2'd0, 32'hFF);
    tick();
    chk("t4_req", 32'(irq_req), 32'h1);
    chk("t4_vec1", irq_vector, 32'h0001_0004);
    pulse_take();
    reg_read(2'd2, d);
    chk("t4_takeclr", d, 32'h00);
    pulse_ret();
    reg_write(2'd1, 32'h00);
    tick(2);

    // 5: underflow
    pulse_ret();
    reg_read(2'd3, d);
    chk("t5_uflow", d, 32'h100);
    reg_write(2'd3, 32'h100);
    reg_read(2'd3, d);
    chk("t5_uclr", d, 32'h0);

    // 6: reset mid-handler at depth 2 with an edge latch pending
    reg_write(2'd1, 32'h01);
    irq_in[1] = 1'b1;
    tick(3);
    pulse_take();
    irq_in[5] = 1'b1;
    tick(3);
    pulse_take();
    irq_in[0] = 1'b1; tick(); irq_in[0] = 1'b0;
    tick(2);
    reg_read(2'd3, d);
    chk("t6_pre", d, 32'h26);
    irq_in = '0;
    nreset = 1'b0;
    tick();
    chk("t6_req", 32'(irq_req), 32'h0);
    chk("t6_vector", irq_vector, 32'h0001_0000);
    chk("t6_ack", 32'(irq_ack), 32'h0);
    chk("t6_rdata", reg_rdata, 32'h0);
    nreset = 1'b1;
    tick();
    reg_read(2'd3, d);
    chk("t6_status", d, 32'h0);
    reg_read(2'd2, d);
    chk("t6_pending", d, 32'h0);
    reg_read(2'd0, d);
    chk("t6_enable", d, 32'hFF);
    reg_read(2'd1, d);
    chk("t6_mode", d, 32'h0);
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tiny32_intc.md
# tiny32_intc

Parametrised, nesting-capable vectored interrupt controller for the tiny32 core family. It replaces the fixed 8-line, single-level, level-only interrupt scheme with:
- N channels, each with a per-channel enable mask and a per-channel edge/level mode;
- fixed priority, where the higher channel index wins;
- a bounded nesting stack, so a higher-priority request can pre-empt an active handler.

It sits between peripheral interrupt lines and the core's interrupt entry/return logic. It also has a small register port on the data bus.

## Interface

Parameters:
- NUM_IRQ, 8, number of channels, 1..15; channel i has interrupt number i+1, and 0 means none.
- NEST_DEPTH, 2, maximum simultaneously active handlers, 1..15.
- ISR_ADDRESS, 24'h0, vector base; vector = {ISR_ADDRESS, 2'b00, number[3:0], 2'b00}.

Ports:
- clk  in  1  clock; all logic on rising edge.
- nreset  in  1  reset nreset, synchronous, active-low; clock clk.
- irq_in  in  NUM_IRQ  raw interrupt lines, asynchronous to clk.
- irq_req  out  1  registered request to core.
- irq_vector  out  32  registered handler address for the current winner.
- irq_take  in  1  one-cycle pulse: core enters the handler at irq_vector.
- irq_ret  in  1  one-cycle pulse: core executed reti.
- irq_ack  out  NUM_IRQ  one-hot of the channel at the top of the stack; 0 when none is active.
- reg_sel  in  1  register access strobe.
- reg_wr  in  1  1 = write, 0 = read.
- reg_addr  in  2  register index.
- reg_wdata  in  32  write data.
- reg_rdata  out  32  registered read data.

## Operation

Registers:
- 0 ENABLE: bit i enables channel i. Reset value: all NUM_IRQ bits set.
- 1 MODE: bit i = 1 selects edge mode, 0 selects level mode. Reset value: 0.
- 2 PENDING: read returns the pending vector. Writing 1 to a bit clears that edge latch; the write has no effect on level-mode bits.
- 3 STATUS:
  - [3:0] number at the top of the stack;
  - [7:4] depth;
  - [8] sticky underflow, cleared by writing 1 to bit 8;
  - all other bits read 0.

Pending logic:
- irq_in is registered once into sync.
- Level mode: pending[i] <= sync[i].
- Edge mode: pending[i] is set on a rising edge of sync[i] and held until taken or cleared by W1C.

Arbitration:
- eligible = pending & ENABLE; the highest eligible index wins.
- Pre-emption: the request is raised only if the winner's number > top-of-stack number AND depth < NEST_DEPTH.

Take and return:
- irq_take while irq_req=1:
  - push the winner's number onto the stack;
  - clear the edge latch of that channel.
- irq_take while irq_req=0 is ignored.
- irq_ret pops the stack. On an empty stack it sets underflow and changes nothing else.
- Simultaneous irq_ret and irq_take: the pop is applied first, then the push.

Precedence rules:
- A rising edge on the same cycle as a take-clear or W1C leaves pending set (set wins).
- Changing MODE from edge to level discards the latch; pending follows sync from the next cycle.
- A bus write and a take in the same cycle are both applied.

## Timing

- Reset values: irq_req=0, irq_vector={ISR_ADDRESS,8'h00}, irq_ack=0, reg_rdata=0. Stack, depth, sync, pending and underflow are all cleared.
- A reset asserted mid-handler abandons all nesting; there is no pending carry-over.
- Request latency, irq_in rising to irq_req=1: 3 clk edges (sync, pending, irq_req).
- irq_vector is updated on the same edge as irq_req and is valid whenever irq_req=1.
- After the irq_take edge:
  - irq_req and irq_vector are recomputed on the next edge;
  - irq_req deasserts one cycle after the take unless another eligible, higher-priority channel qualifies.
- irq_ack and STATUS reflect a push or pop on the edge after irq_take or irq_ret.
- A register write takes effect at the edge where reg_sel & reg_wr; its effect on irq_req appears one edge later.
- Reads: reg_rdata is valid the cycle after reg_sel & !reg_wr and holds its value until the next read.

## Test plan

1. Level IRQ on ch2 (ISR_ADDRESS=24'h000100, all others idle) → irq_req=1 exactly 3 edges after the irq_in rise, irq_vector=32'h00010000|(3<<2)=32'h0001000C. Pulse take → irq_ack=8'h04, STATUS[3:0]=3, STATUS[7:4]=1.
2. Priority: ch1 and ch6 rise on the same cycle → vector number 7. Take, then ret → vector number 2 is presented next.
3. Nesting with NEST_DEPTH=2:
   - take ch1, then ch5 rises → req, take, depth=2;
   - ch7 rises → irq_req stays 0 (depth full);
   - ret → ch7 is requested.
4. Edge mode on ch0: a 1-cycle irq_in pulse latches pending=1. With ENABLE[0]=0 there is no req. W1C on the same cycle as a new rising edge → pending stays 1. Enable → req with number 1.
5. irq_ret with an empty stack → STATUS[8]=1 and no other state change. Write 32'h100 to STATUS → bit cleared.
6. nreset asserted at depth 2 with pending edges → the next cycle shows all outputs at reset values and STATUS=0.
